cu_op_arbiter: RTL and testbench
================================

# cu_op_arbiter

Two-requester sequencer and arbiter for the 4-bit computational unit. It accepts ALU operation requests (opcode plus two 4-bit operands) from two independent masters and arbitrates between them round-robin. Each granted request is sequenced through the unit's control inputs: load x0, load y0, execute into r, and write back r to o_reg. The result nibble and zero flag are returned with the requester ID. The block sits between the masters and the computational unit and is the only driver of the unit's control inputs.

## Interface

Parameters:
- OREG_WB, default 1: when 1, the write-back state also asserts reg_en[8], so the result is copied into o_reg; when 0, o_reg is untouched.

Ports:
- clk  input  1  rising-edge clock, shared with the computational unit
- reset_n  input  1  asynchronous, active-low reset; one clock domain
- req0, req1  input  1 each  request from master 0 / master 1; held with its operands until acked
- op0, op1  input  3 each  ALU function for each master (0 neg, 1 sub, 2 add, 3 mul-MS, 4 mul-LS, 5 xor, 6 and, 7 not)
- a0, a1  input  4 each  x operand for each master
- b0, b1  input  4 each  y operand for each master
- ack0, ack1  output  1 each  grant/accept for each master; at most one is high in any cycle
- rsp_valid  output  1  one-cycle pulse: response fields are valid
- rsp_id  output  1  ID of the master whose result is presented
- rsp_data  output  4  result nibble
- rsp_zero  output  1  zero flag accompanying the result
- data_bus  input  4  the computational unit's data_bus
- r_eq_0  input  1  the computational unit's zero flag
- source_sel  output  4  drives the unit's source_sel
- nibble_ir  output  4  drives the unit's nibble_ir
- reg_en  output  9  drives the unit's register enables
- x_sel, y_sel, i_sel  output  1 each  drive the unit's selects; always 0

## Operation

- The FSM has five states: IDLE, LDX, LDY, EXE, WB.
  - IDLE → LDX when req0 or req1 is high at a clock edge; otherwise stay in IDLE.
  - LDX → LDY → EXE → WB → IDLE unconditionally.
- Arbitration happens only in IDLE.
  - One requester high: that requester wins.
  - Both high: the requester other than last_grant wins.
  - last_grant resets to 1, so master 0 wins the first tie.
- ackN is combinational: high when state == IDLE and master N is the current winner. At the edge where ack is high, the winner's op, a, b and ID are latched and last_grant is updated.
- Control outputs are decoded from the state and the latched registers only. There is no input-to-output combinational path except ack.
  - IDLE: source_sel=10 (bus 0), nibble_ir=0, reg_en=0.
  - LDX: source_sel=8, nibble_ir=a, reg_en[0]=1 (x0 ← a).
  - LDY: source_sel=8, nibble_ir=b, reg_en[2]=1 (y0 ← b).
  - EXE: source_sel=10, nibble_ir={1'b0,op}, reg_en[4]=1 (r ← alu(x0,y0)).
  - WB: source_sel=4 (bus = r), reg_en[8]=OREG_WB.
  - All other reg_en bits are 0 in every state. The block never writes x1, y1, m or i.
- At the WB→IDLE edge: rsp_data ← data_bus, rsp_zero ← r_eq_0, rsp_id ← latched ID, rsp_valid ← 1. rsp_valid clears at the next edge. rsp_data, rsp_zero and rsp_id hold until the next response.
- Results follow 4-bit wrap-around arithmetic, as computed by the unit. The block does no arithmetic itself.
- The unit's own sync_reset is not driven by this block.

## Timing

- The acceptance edge is E0 (ack high in the cycle before it).
- LDX occupies the cycle after E0, LDY after E1, EXE after E2, WB after E3.
- rsp_valid is high in the cycle after E4: latency is 4 edges from acceptance.
- r and r_eq_0 update at E3 and are sampled at E4.
- Throughput: one operation per 5 cycles.
  - A new request can be acked in the same IDLE cycle in which rsp_valid is high.
  - Back-to-back requests give rsp_valid every 5th cycle.
- A request that arrives while not in IDLE waits; ack stays low until the next IDLE.
- Asynchronous reset, while reset_n is low:
  - State → IDLE, last_grant → 1, rsp_valid → 0.
  - rsp_data → 0, rsp_zero → 0, rsp_id → 0.
  - Latched operands → 0.
  - reg_en → 0 immediately, without waiting for a clock.
- Reset mid-operation: the in-flight operation is dropped with no response. Unit registers keep whatever was written before reset. The first edge after reset release with a request pending starts a fresh sequence.
- Deasserting a request before ack is legal; the request is simply not taken.

## Test plan

- Reset: hold reset_n=0 with req0=1 → ack0=0, reg_en=0, rsp_valid=0, source_sel=10. After release, ack0 is high in the first cycle.
- req0 with op=2, a=3, b=4 → reg_en sequence 0x001, 0x004, 0x010, 0x100; rsp_valid 4 edges after acceptance with rsp_data=7, rsp_zero=0, rsp_id=0; o_reg=7.
- Arithmetic on master 1:
  - op=1, a=5, b=5 → data 0, zero 1.
  - op=3, a=F, b=F → data E.
  - op=4, a=F, b=F → data 1.
  - op=0, a=0 → data 0, zero 1.
  - op=7, a=F → data 0, zero 1.
- Contention: req0 and req1 both held high for 4 operations → grant order 0,1,0,1; rsp_valid every 5 cycles; rsp_id matches the grant order.
- Reset mid-operation: pull reset_n low during EXE → no rsp_valid. A subsequent req1 (op=2, a=1, b=1) returns 2 with normal latency.
- OREG_WB=0: op=2, a=1, b=2 → rsp_data=3 and reg_en[8] never asserted.

Source files
------------

// File: rtl/cu_op_arbiter_if.sv
// Request/response bus between the two ALU masters and cu_op_arbiter.
// The master modport describes the requester side; slave is the arbiter side.
interface cu_op_arbiter_if;
    logic       req0;
    logic       req1;
    logic [2:0] op0;
    logic [2:0] op1;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [3:0] b0;
    logic [3:0] b1;
    logic       ack0;
    logic       ack1;
    logic       rsp_valid;
    logic       rsp_id;
    logic [3:0] rsp_data;
    logic       rsp_zero;

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1,
        input  ack0, ack1, rsp_valid, rsp_id, rsp_data, rsp_zero
    );

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1,
        output ack0, ack1, rsp_valid, rsp_id, rsp_data, rsp_zero
    );
endinterface

// File: rtl/cu_op_arbiter.sv
// Round-robin arbiter for two ALU masters that sequences each granted op through
// the 4-bit computational unit (load x0, load y0, execute, write back) and returns the result.
module cu_op_arbiter #(
    parameter bit OREG_WB = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cu_op_arbiter_if.slave        bus,
    input  logic [3:0]            data_bus,
    input  logic                  r_eq_0,
    output logic [3:0]            source_sel,
    output logic [3:0]            nibble_ir,
    output logic [8:0]            reg_en,
    output logic                  x_sel,
    output logic                  y_sel,
    output logic                  i_sel
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDX  = 3'd1;
    localparam logic [2:0] S_LDY  = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_grant;
    logic       win0;
    logic       win1;
    logic       grant_ok;
    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       id_q;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic [3:0] rsp_data_q;
    logic       rsp_zero_q;

    // On a tie the master that was not granted last time wins.
    assign win0     = bus.req0 && (!bus.req1 || last_grant);
    assign win1     = bus.req1 && (!bus.req0 || !last_grant);
    assign grant_ok = reset_n && (state == S_IDLE);

    assign bus.ack0      = grant_ok && win0;
    assign bus.ack1      = grant_ok && win1;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;

    assign x_sel = 1'b0;
    assign y_sel = 1'b0;
    assign i_sel = 1'b0;

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = (bus.req0 || bus.req1) ? S_LDX : S_IDLE;
            S_LDX:   state_nxt = S_LDY;
            S_LDY:   state_nxt = S_EXE;
            S_EXE:   state_nxt = S_WB;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            op_q        <= 3'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= (state == S_WB);
            if (state == S_IDLE && (win0 || win1)) begin
                op_q       <= win1 ? bus.op1 : bus.op0;
                a_q        <= win1 ? bus.a1  : bus.a0;
                b_q        <= win1 ? bus.b1  : bus.b0;
                id_q       <= win1;
                last_grant <= win1;
            end
            // Result is on the bus during WB because source_sel selects r.
            if (state == S_WB) begin
                rsp_data_q <= data_bus;
                rsp_zero_q <= r_eq_0;
                rsp_id_q   <= id_q;
            end
        end
    end

    always_comb begin
        source_sel = 4'd10;
        nibble_ir  = 4'd0;
        reg_en     = 9'd0;
        case (state)
            S_LDX: begin
                source_sel = 4'd8;
                nibble_ir  = a_q;
                reg_en[0]  = 1'b1;
            end
            S_LDY: begin
                source_sel = 4'd8;
                nibble_ir  = b_q;
                reg_en[2]  = 1'b1;
            end
            S_EXE: begin
                source_sel = 4'd10;
                nibble_ir  = {1'b0, op_q};
                reg_en[4]  = 1'b1;
            end
            S_WB: begin
                source_sel = 4'd4;
                reg_en[8]  = OREG_WB;
            end
            default: begin
                source_sel = 4'd10;
            end
        endcase
    end
endmodule

// File: tb/tb_cu_op_arbiter.sv
// Directed bench for cu_op_arbiter with a behavioural model of the 4-bit computational unit.
// A second instance with OREG_WB=0 checks that write-back to o_reg is suppressed.
module tb_cu_op_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cu_op_arbiter_if ifc ();
    cu_op_arbiter_if ifc2 ();

    logic [3:0] data_bus, data_bus2;
    logic       r_eq_0, r_eq_02;
    logic [3:0] source_sel, source_sel2, nibble_ir, nibble_ir2;
    logic [8:0] reg_en, reg_en2;
    logic       x_sel, y_sel, i_sel, x_sel2, y_sel2, i_sel2;

    cu_op_arbiter #(.OREG_WB(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(ifc.slave),
        .data_bus(data_bus), .r_eq_0(r_eq_0),
        .source_sel(source_sel), .nibble_ir(nibble_ir), .reg_en(reg_en),
        .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel)
    );

    cu_op_arbiter #(.OREG_WB(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(ifc2.slave),
        .data_bus(data_bus2), .r_eq_0(r_eq_02),
        .source_sel(source_sel2), .nibble_ir(nibble_ir2), .reg_en(reg_en2),
        .x_sel(x_sel2), .y_sel(y_sel2), .i_sel(i_sel2)
    );

    function automatic logic [3:0] alu(input logic [2:0] f, input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = {4'd0, x} * {4'd0, y};
        case (f)
            3'd0:    return 4'd0 - x;
            3'd1:    return x - y;
            3'd2:    return x + y;
            3'd3:    return p[7:4];
            3'd4:    return p[3:0];
            3'd5:    return x ^ y;
            3'd6:    return x & y;
            default: return ~x;
        endcase
    endfunction

    // Computational unit models (registers are not affected by the arbiter's reset).
    logic [3:0] x0 = 4'd0, y0 = 4'd0, r = 4'd0, o_reg = 4'd0;
    logic [3:0] x0b = 4'd0, y0b = 4'd0, rb = 4'd0, o_regb = 4'd0;
    logic       seen_wb8_2 = 1'b0;

    always_comb begin
        case (source_sel)
            4'd8:    data_bus = nibble_ir;
            4'd4:    data_bus = r;
            default: data_bus = 4'd0;
        endcase
        case (source_sel2)
            4'd8:    data_bus2 = nibble_ir2;
            4'd4:    data_bus2 = rb;
            default: data_bus2 = 4'd0;
        endcase
    end
    assign r_eq_0  = (r == 4'd0);
    assign r_eq_02 = (rb == 4'd0);

    always @(posedge clk) begin
        if (reg_en[0]) x0 <= data_bus;
        if (reg_en[2]) y0 <= data_bus;
        if (reg_en[4]) r <= alu(nibble_ir[2:0], x0, y0);
        if (reg_en[8]) o_reg <= data_bus;
        if (reg_en2[0]) x0b <= data_bus2;
        if (reg_en2[2]) y0b <= data_bus2;
        if (reg_en2[4]) rb <= alu(nibble_ir2[2:0], x0b, y0b);
        if (reg_en2[8]) o_regb <= data_bus2;
        if (reg_en2[8]) seen_wb8_2 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from master id, then check the response 4 edges after acceptance.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ed, input logic ez, input string tag);
        if (id) begin
            ifc.req1 = 1'b1; ifc.op1 = op; ifc.a1 = a; ifc.b1 = b;
        end else begin
            ifc.req0 = 1'b1; ifc.op0 = op; ifc.a0 = a; ifc.b0 = b;
        end
        #1;
        chk({tag, "_ack"}, {15'd0, id ? ifc.ack1 : ifc.ack0}, 16'd1);
        step();
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;
        repeat (3) step();
        chk({tag, "_pre_valid"}, {15'd0, ifc.rsp_valid}, 16'd0);
        step();
        chk({tag, "_valid"}, {15'd0, ifc.rsp_valid}, 16'd1);
        chk({tag, "_data"}, {12'd0, ifc.rsp_data}, {12'd0, ed});
        chk({tag, "_zero"}, {15'd0, ifc.rsp_zero}, {15'd0, ez});
        chk({tag, "_id"}, {15'd0, ifc.rsp_id}, {15'd0, id});
    endtask

    initial begin
        logic any_valid;
        logic w;
        ifc.req0 = 1'b1; ifc.op0 = 3'd2; ifc.a0 = 4'd3; ifc.b0 = 4'd4;
        ifc.req1 = 1'b0; ifc.op1 = 3'd0; ifc.a1 = 4'd0; ifc.b1 = 4'd0;
        ifc2.req0 = 1'b0; ifc2.op0 = 3'd0; ifc2.a0 = 4'd0; ifc2.b0 = 4'd0;
        ifc2.req1 = 1'b0; ifc2.op1 = 3'd0; ifc2.a1 = 4'd0; ifc2.b1 = 4'd0;

        repeat (3) step();
        chk("rst_ack0", {15'd0, ifc.ack0}, 16'd0);
        chk("rst_reg_en", {7'd0, reg_en}, 16'h000);
        chk("rst_valid", {15'd0, ifc.rsp_valid}, 16'd0);
        chk("rst_src", {12'd0, source_sel}, 16'd10);
        chk("rst_data", {12'd0, ifc.rsp_data}, 16'd0);
        chk("rst_sels", {13'd0, x_sel, y_sel, i_sel}, 16'd0);

        reset_n = 1'b1;
        #1;
        chk("post_rst_ack0", {15'd0, ifc.ack0}, 16'd1);
        chk("post_rst_ack1", {15'd0, ifc.ack1}, 16'd0);

        step();
        ifc.req0 = 1'b0;
        chk("ldx_reg_en", {7'd0, reg_en}, 16'h001);
        chk("ldx_src", {12'd0, source_sel}, 16'd8);
        chk("ldx_nib", {12'd0, nibble_ir}, 16'd3);
        step();
        chk("ldy_reg_en", {7'd0, reg_en}, 16'h004);
        chk("ldy_nib", {12'd0, nibble_ir}, 16'd4);
        step();
        chk("exe_reg_en", {7'd0, reg_en}, 16'h010);
        chk("exe_nib", {12'd0, nibble_ir}, 16'd2);
        chk("exe_src", {12'd0, source_sel}, 16'd10);
        step();
        chk("wb_reg_en", {7'd0, reg_en}, 16'h100);
        chk("wb_src", {12'd0, source_sel}, 16'd4);
        chk("wb_valid", {15'd0, ifc.rsp_valid}, 16'd0);
        step();
        chk("add_valid", {15'd0, ifc.rsp_valid}, 16'd1);
        chk("add_data", {12'd0, ifc.rsp_data}, 16'd7);
        chk("add_zero", {15'd0, ifc.rsp_zero}, 16'd0);
        chk("add_id", {15'd0, ifc.rsp_id}, 16'd0);
        chk("add_oreg", {12'd0, o_reg}, 16'd7);
        step();
        chk("pulse_clear", {15'd0, ifc.rsp_valid}, 16'd0);
        chk("data_hold", {12'd0, ifc.rsp_data}, 16'd7);

        run_op(1'b1, 3'd1, 4'h5, 4'h5, 4'h0, 1'b1, "sub");
        run_op(1'b1, 3'd3, 4'hF, 4'hF, 4'hE, 1'b0, "mulms");
        run_op(1'b1, 3'd4, 4'hF, 4'hF, 4'h1, 1'b0, "mulls");
        run_op(1'b1, 3'd0, 4'h0, 4'h3, 4'h0, 1'b1, "neg");
        run_op(1'b1, 3'd7, 4'hF, 4'h0, 4'h0, 1'b1, "not");

        // Contention: master 0 computes 1+1, master 1 computes C&A.
        ifc.req0 = 1'b1; ifc.op0 = 3'd2; ifc.a0 = 4'h1; ifc.b0 = 4'h1;
        ifc.req1 = 1'b1; ifc.op1 = 3'd6; ifc.a1 = 4'hC; ifc.b1 = 4'hA;
        #1;
        for (int k = 0; k < 4; k++) begin
            w = k[0];
            chk($sformatf("cont%0d_ack0", k), {15'd0, ifc.ack0}, {15'd0, !w});
            chk($sformatf("cont%0d_ack1", k), {15'd0, ifc.ack1}, {15'd0, w});
            if (k > 0) begin
                chk($sformatf("cont%0d_valid", k), {15'd0, ifc.rsp_valid}, 16'd1);
                chk($sformatf("cont%0d_id", k), {15'd0, ifc.rsp_id}, {15'd0, !w});
                chk($sformatf("cont%0d_data", k), {12'd0, ifc.rsp_data}, w ? 16'd2 : 16'd8);
            end
            step();
            chk($sformatf("cont%0d_busy_ack", k), {14'd0, ifc.ack0, ifc.ack1}, 16'd0);
            chk($sformatf("cont%0d_gap", k), {15'd0, ifc.rsp_valid}, 16'd0);
            repeat (4) step();
        end
        chk("cont_last_valid", {15'd0, ifc.rsp_valid}, 16'd1);
        chk("cont_last_id", {15'd0, ifc.rsp_id}, 16'd1);
        chk("cont_last_data", {12'd0, ifc.rsp_data}, 16'd8);
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;
        step();

        // Reset during EXE drops the operation.
        ifc.req0 = 1'b1; ifc.op0 = 3'd5; ifc.a0 = 4'h3; ifc.b0 = 4'h5;
        step();
        ifc.req0 = 1'b0;
        step();
        step();
        chk("mid_exe_reg_en", {7'd0, reg_en}, 16'h010);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_reg_en", {7'd0, reg_en}, 16'h000);
        chk("mid_rst_src", {12'd0, source_sel}, 16'd10);
        chk("mid_rst_data", {12'd0, ifc.rsp_data}, 16'd0);
        step();
        step();
        reset_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            any_valid = any_valid | ifc.rsp_valid;
        end
        chk("mid_rst_no_rsp", {15'd0, any_valid}, 16'd0);
        run_op(1'b1, 3'd2, 4'h1, 4'h1, 4'h2, 1'b0, "post_rst");

        // OREG_WB = 0 instance.
        step();
        ifc2.req0 = 1'b1; ifc2.op0 = 3'd2; ifc2.a0 = 4'h1; ifc2.b0 = 4'h2;
        #1;
        chk("nowb_ack", {15'd0, ifc2.ack0}, 16'd1);
        step();
        ifc2.req0 = 1'b0;
        repeat (3) step();
        chk("nowb_wb_reg_en", {7'd0, reg_en2}, 16'h000);
        chk("nowb_wb_src", {12'd0, source_sel2}, 16'd4);
        step();
        chk("nowb_valid", {15'd0, ifc2.rsp_valid}, 16'd1);
        chk("nowb_data", {12'd0, ifc2.rsp_data}, 16'd3);
        chk("nowb_never_en8", {15'd0, seen_wb8_2}, 16'd0);
        chk("nowb_oreg", {12'd0, o_regb}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
